// File: rtl/jelly_stepper_motor_regs_pkg.sv
// Shared definitions for the stepper-motor controller register block:
// bus geometry, register word indices, CTL bit positions and write/read helpers.
package jelly_stmc_regs_pkg;

  localparam int WB_ADR_WIDTH = 8;
  localparam int WB_DAT_WIDTH = 64;
  localparam int WB_SEL_WIDTH = WB_DAT_WIDTH / 8;
  localparam int X_WIDTH      = 32;

  localparam logic [31:0] STMC_CORE_ID = 32'h527a_f010;

  localparam logic [WB_ADR_WIDTH-1:0] REG_STMC_CORE_ID    = 8'h00;
  localparam logic [WB_ADR_WIDTH-1:0] REG_STMC_CTL_ENABLE = 8'h01;
  localparam logic [WB_ADR_WIDTH-1:0] REG_STMC_CTL_TARGET = 8'h02;
  localparam logic [WB_ADR_WIDTH-1:0] REG_STMC_CTL_PWM    = 8'h03;
  localparam logic [WB_ADR_WIDTH-1:0] REG_STMC_TARGET_X   = 8'h04;
  localparam logic [WB_ADR_WIDTH-1:0] REG_STMC_TARGET_V   = 8'h06;
  localparam logic [WB_ADR_WIDTH-1:0] REG_STMC_TARGET_A   = 8'h07;
  localparam logic [WB_ADR_WIDTH-1:0] REG_STMC_MAX_V      = 8'h09;
  localparam logic [WB_ADR_WIDTH-1:0] REG_STMC_MAX_A      = 8'h0a;
  localparam logic [WB_ADR_WIDTH-1:0] REG_STMC_MAX_A_NEAR = 8'h0f;
  localparam logic [WB_ADR_WIDTH-1:0] REG_STMC_CUR_X      = 8'h10;
  localparam logic [WB_ADR_WIDTH-1:0] REG_STMC_CUR_V      = 8'h12;
  localparam logic [WB_ADR_WIDTH-1:0] REG_STMC_CUR_A      = 8'h13;

  localparam int CTL_ENABLE_BIT    = 0;
  localparam int CTL_IMMEDIATE_BIT = 1;
  localparam int CTL_UPDATE_BIT    = 0;
  localparam int CTL_AUTO_BIT      = 1;
  localparam int CTL_PWM_BIT       = 0;

  function automatic logic [X_WIDTH-1:0] mask_write(
    input logic [X_WIDTH-1:0]   cur,
    input logic [X_WIDTH-1:0]   dat,
    input logic [X_WIDTH/8-1:0] sel
  );
    logic [X_WIDTH-1:0] res;
    res = cur;
    for (int i = 0; i < X_WIDTH / 8; i++) begin
      if (sel[i]) res[8*i +: 8] = dat[8*i +: 8];
    end
    return res;
  endfunction

  function automatic logic [WB_DAT_WIDTH-1:0] sext_x(input logic [X_WIDTH-1:0] v);
    return {{(WB_DAT_WIDTH-X_WIDTH){v[X_WIDTH-1]}}, v};
  endfunction

endpackage

// File: rtl/jelly_stepper_motor_regs_if.sv
// WISHBONE single-word slave bus bundle for the stepper-motor register block.
interface jelly_stepper_motor_regs_if
  import jelly_stmc_regs_pkg::*;
  ();
  // Handshake: a request is taken when stb is high and ack is low; ack pulses
  // for exactly one cycle after the sampling edge, and read data is valid with it.
  logic [WB_ADR_WIDTH-1:0] s_wb_adr_i;
  logic [WB_DAT_WIDTH-1:0] s_wb_dat_i;
  logic [WB_DAT_WIDTH-1:0] s_wb_dat_o;
  logic                    s_wb_we_i;
  logic [WB_SEL_WIDTH-1:0] s_wb_sel_i;
  logic                    s_wb_stb_i;
  logic                    s_wb_ack_o;

  modport slave (
    input  s_wb_adr_i, s_wb_dat_i, s_wb_we_i, s_wb_sel_i, s_wb_stb_i,
    output s_wb_dat_o, s_wb_ack_o
  );

  modport master (
    output s_wb_adr_i, s_wb_dat_i, s_wb_we_i, s_wb_sel_i, s_wb_stb_i,
    input  s_wb_dat_o, s_wb_ack_o
  );
endinterface

// File: rtl/jelly_stepper_motor_regs.sv
// Stepper-motor controller register block: shadow registers moved to the active
// set on update_trig. Define JELLY_STMC_REGS_STATUS_EN to expose cur_x/v/a reads.
module jelly_stepper_motor_regs
  import jelly_stmc_regs_pkg::*;
#(
  parameter logic [31:0] CORE_ID = STMC_CORE_ID
)(
  input  logic                      reset,
  input  logic                      clk,
  jelly_stepper_motor_regs_if.slave s_wb,
  input  logic                      update_trig,
  output logic                      enable,
  output logic                      target_en,
  output logic                      pwm_en,
  output logic signed [X_WIDTH-1:0] target_x,
  output logic signed [X_WIDTH-1:0] target_v,
  output logic signed [X_WIDTH-1:0] target_a,
  output logic signed [X_WIDTH-1:0] max_v,
  output logic signed [X_WIDTH-1:0] max_a,
  output logic signed [X_WIDTH-1:0] max_a_near,
  input  logic signed [X_WIDTH-1:0] cur_x,
  input  logic signed [X_WIDTH-1:0] cur_v,
  input  logic signed [X_WIDTH-1:0] cur_a
);

  logic                    r_ack;
  logic [WB_DAT_WIDTH-1:0] r_dat;
  logic [1:0]              r_sh_ctl_enable, r_ctl_target;
  logic                    r_sh_ctl_pwm;
  logic [X_WIDTH-1:0]      r_sh_target_x, r_sh_target_v, r_sh_target_a;
  logic [X_WIDTH-1:0]      r_sh_max_v, r_sh_max_a, r_sh_max_a_near;
  logic                    r_enable, r_target_en, r_pwm_en;
  logic [X_WIDTH-1:0]      r_target_x, r_target_v, r_target_a;
  logic [X_WIDTH-1:0]      r_max_v, r_max_a, r_max_a_near;

  logic                    w_access, w_wr, w_xfer;
  logic [X_WIDTH-1:0]      w_wdat;
  logic [X_WIDTH/8-1:0]    w_wsel;
  logic [1:0]              w_nx_ctl_enable, w_nx_ctl_target;
  logic                    w_nx_ctl_pwm;
  logic [X_WIDTH-1:0]      w_nx_target_x, w_nx_target_v, w_nx_target_a;
  logic [X_WIDTH-1:0]      w_nx_max_v, w_nx_max_a, w_nx_max_a_near;
  logic [WB_DAT_WIDTH-1:0] w_rdata;
  logic                    w_unused_bus;

  assign w_access     = s_wb.s_wb_stb_i & ~r_ack;
  assign w_wr         = w_access & s_wb.s_wb_we_i;
  assign w_xfer       = update_trig & r_ctl_target[CTL_UPDATE_BIT];
  assign w_wdat       = s_wb.s_wb_dat_i[X_WIDTH-1:0];
  assign w_wsel       = s_wb.s_wb_sel_i[X_WIDTH/8-1:0];
  assign w_unused_bus = ^{s_wb.s_wb_dat_i[WB_DAT_WIDTH-1:X_WIDTH],
                          s_wb.s_wb_sel_i[WB_SEL_WIDTH-1:X_WIDTH/8]};

  always_comb begin
    w_nx_ctl_enable = r_sh_ctl_enable;
    w_nx_ctl_pwm    = r_sh_ctl_pwm;
    w_nx_target_x   = r_sh_target_x;
    w_nx_target_v   = r_sh_target_v;
    w_nx_target_a   = r_sh_target_a;
    w_nx_max_v      = r_sh_max_v;
    w_nx_max_a      = r_sh_max_a;
    w_nx_max_a_near = r_sh_max_a_near;
    w_nx_ctl_target = r_ctl_target;
    if (w_xfer && !r_ctl_target[CTL_AUTO_BIT]) w_nx_ctl_target[CTL_UPDATE_BIT] = 1'b0;
    if (w_wr) begin
      case (s_wb.s_wb_adr_i)
        REG_STMC_CTL_ENABLE: if (w_wsel[0]) w_nx_ctl_enable = w_wdat[1:0];
        // A host write overrides the auto-clear so a fresh request is never lost.
        REG_STMC_CTL_TARGET: if (w_wsel[0]) w_nx_ctl_target = w_wdat[1:0];
        REG_STMC_CTL_PWM:    if (w_wsel[0]) w_nx_ctl_pwm = w_wdat[CTL_PWM_BIT];
        REG_STMC_TARGET_X:   w_nx_target_x   = mask_write(r_sh_target_x, w_wdat, w_wsel);
        REG_STMC_TARGET_V:   w_nx_target_v   = mask_write(r_sh_target_v, w_wdat, w_wsel);
        REG_STMC_TARGET_A:   w_nx_target_a   = mask_write(r_sh_target_a, w_wdat, w_wsel);
        REG_STMC_MAX_V:      w_nx_max_v      = mask_write(r_sh_max_v, w_wdat, w_wsel);
        REG_STMC_MAX_A:      w_nx_max_a      = mask_write(r_sh_max_a, w_wdat, w_wsel);
        REG_STMC_MAX_A_NEAR: w_nx_max_a_near = mask_write(r_sh_max_a_near, w_wdat, w_wsel);
        default: ;
      endcase
    end
  end

`ifdef JELLY_STMC_REGS_STATUS_EN
  logic [X_WIDTH-1:0] r_cur_x, r_cur_v, r_cur_a;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_cur_x <= '0;
      r_cur_v <= '0;
      r_cur_a <= '0;
    end else begin
      r_cur_x <= cur_x;
      r_cur_v <= cur_v;
      r_cur_a <= cur_a;
    end
  end
`else
  logic w_unused_status;
  assign w_unused_status = ^{cur_x, cur_v, cur_a};
`endif

  always_comb begin
    w_rdata = '0;
    case (s_wb.s_wb_adr_i)
      REG_STMC_CORE_ID:    w_rdata = sext_x(CORE_ID);
      REG_STMC_CTL_ENABLE: w_rdata = {{(WB_DAT_WIDTH-2){1'b0}}, r_sh_ctl_enable};
      REG_STMC_CTL_TARGET: w_rdata = {{(WB_DAT_WIDTH-2){1'b0}}, r_ctl_target};
      REG_STMC_CTL_PWM:    w_rdata = {{(WB_DAT_WIDTH-1){1'b0}}, r_sh_ctl_pwm};
      REG_STMC_TARGET_X:   w_rdata = sext_x(r_sh_target_x);
      REG_STMC_TARGET_V:   w_rdata = sext_x(r_sh_target_v);
      REG_STMC_TARGET_A:   w_rdata = sext_x(r_sh_target_a);
      REG_STMC_MAX_V:      w_rdata = sext_x(r_sh_max_v);
      REG_STMC_MAX_A:      w_rdata = sext_x(r_sh_max_a);
      REG_STMC_MAX_A_NEAR: w_rdata = sext_x(r_sh_max_a_near);
`ifdef JELLY_STMC_REGS_STATUS_EN
      REG_STMC_CUR_X:      w_rdata = sext_x(r_cur_x);
      REG_STMC_CUR_V:      w_rdata = sext_x(r_cur_v);
      REG_STMC_CUR_A:      w_rdata = sext_x(r_cur_a);
`endif
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_ack           <= 1'b0;
      r_dat           <= '0;
      r_sh_ctl_enable <= '0;
      r_ctl_target    <= '0;
      r_sh_ctl_pwm    <= 1'b0;
      r_sh_target_x   <= '0;
      r_sh_target_v   <= '0;
      r_sh_target_a   <= '0;
      r_sh_max_v      <= '0;
      r_sh_max_a      <= '0;
      r_sh_max_a_near <= '0;
      r_enable        <= 1'b0;
      r_target_en     <= 1'b0;
      r_pwm_en        <= 1'b0;
      r_target_x      <= '0;
      r_target_v      <= '0;
      r_target_a      <= '0;
      r_max_v         <= '0;
      r_max_a         <= '0;
      r_max_a_near    <= '0;
    end else begin
      r_ack <= s_wb.s_wb_stb_i & ~r_ack;
      if (w_access) r_dat <= w_rdata;
      r_sh_ctl_enable <= w_nx_ctl_enable;
      r_ctl_target    <= w_nx_ctl_target;
      r_sh_ctl_pwm    <= w_nx_ctl_pwm;
      r_sh_target_x   <= w_nx_target_x;
      r_sh_target_v   <= w_nx_target_v;
      r_sh_target_a   <= w_nx_target_a;
      r_sh_max_v      <= w_nx_max_v;
      r_sh_max_a      <= w_nx_max_a;
      r_sh_max_a_near <= w_nx_max_a_near;
      // Transfer uses pre-write shadows; target_en marks that targets were loaded.
      if (w_xfer) begin
        r_enable     <= r_sh_ctl_enable[CTL_ENABLE_BIT];
        r_target_en  <= 1'b1;
        r_pwm_en     <= r_sh_ctl_pwm;
        r_target_x   <= r_sh_target_x;
        r_target_v   <= r_sh_target_v;
        r_target_a   <= r_sh_target_a;
        r_max_v      <= r_sh_max_v;
        r_max_a      <= r_sh_max_a;
        r_max_a_near <= r_sh_max_a_near;
      end
      if (w_nx_ctl_enable[CTL_IMMEDIATE_BIT]) r_enable <= w_nx_ctl_enable[CTL_ENABLE_BIT];
    end
  end

  assign s_wb.s_wb_ack_o = r_ack;
  assign s_wb.s_wb_dat_o = r_dat;
  assign enable          = r_enable;
  assign target_en       = r_target_en;
  assign pwm_en          = r_pwm_en;
  assign target_x        = r_target_x;
  assign target_v        = r_target_v;
  assign target_a        = r_target_a;
  assign max_v           = r_max_v;
  assign max_a           = r_max_a;
  assign max_a_near      = r_max_a_near;

endmodule

// File: tb/tb_jelly_stepper_motor_regs.sv
// Self-checking bench for jelly_stepper_motor_regs: directed scenarios, then random
// bus traffic and trigger pulses compared with a register-map reference model.
module tb_jelly_stepper_motor_regs;
  import jelly_stmc_regs_pkg::*;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic update_trig = 1'b0;
  always #5 clk = ~clk;

  jelly_stepper_motor_regs_if wb();

  logic        enable, target_en, pwm_en;
  logic [31:0] target_x, target_v, target_a, max_v, max_a, max_a_near;
  logic [31:0] cur_x, cur_v, cur_a;

  int n_vec = 0;
  int n_err = 0;

  // Reference model: shadow and active contents indexed by word address.
  logic [31:0] m_sh  [0:31];
  logic [31:0] m_act [0:31];
  bit          m_target_en;
  int          xfer_regs [8] = '{1, 3, 4, 6, 7, 9, 10, 15};

  jelly_stepper_motor_regs u_dut (
    .reset       (reset),
    .clk         (clk),
    .s_wb        (wb.slave),
    .update_trig (update_trig),
    .enable      (enable),
    .target_en   (target_en),
    .pwm_en      (pwm_en),
    .target_x    (target_x),
    .target_v    (target_v),
    .target_a    (target_a),
    .max_v       (max_v),
    .max_a       (max_a),
    .max_a_near  (max_a_near),
    .cur_x       (cur_x),
    .cur_v       (cur_v),
    .cur_a       (cur_a)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic int reg_width(input int adr);
    case (adr)
      1, 2:                   return 2;
      3:                      return 1;
      4, 6, 7, 9, 10, 15:     return 32;
      default:                return 0;
    endcase
  endfunction

  function automatic logic [63:0] sx(input logic [31:0] v);
    return {{32{v[31]}}, v};
  endfunction

  function automatic logic [63:0] exp_read(input int adr);
    if (adr == 0) return sx(32'h527a_f010);
    if (reg_width(adr) == 32) return sx(m_sh[adr]);
    if (reg_width(adr) != 0) return {32'h0, m_sh[adr]};
`ifdef JELLY_STMC_REGS_STATUS_EN
    if (adr == 16) return sx(cur_x);
    if (adr == 18) return sx(cur_v);
    if (adr == 19) return sx(cur_a);
`endif
    return 64'h0;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 32; i++) begin
      m_sh[i]  = '0;
      m_act[i] = '0;
    end
    m_target_en = 1'b0;
  endtask

  task automatic model_write(input int adr, input logic [63:0] dat, input logic [7:0] sel);
    int w;
    logic [31:0] v;
    w = reg_width(adr);
    if (w == 0) return;
    v = m_sh[adr];
    for (int b = 0; b < 4; b++) if (sel[b]) v[8*b +: 8] = dat[8*b +: 8];
    if (w < 32) v = v & ((32'd1 << w) - 32'd1);
    m_sh[adr] = v;
  endtask

  task automatic model_trig();
    if (m_sh[2][0]) begin
      foreach (xfer_regs[k]) m_act[xfer_regs[k]] = m_sh[xfer_regs[k]];
      m_target_en = 1'b1;
      if (!m_sh[2][1]) m_sh[2][0] = 1'b0;
    end
  endtask

  task automatic model_settle();
    if (m_sh[1][1]) m_act[1][0] = m_sh[1][0];
  endtask

  task automatic check_outputs(input string ctx);
    check({ctx, ":enable"},     64'(enable),     64'(m_act[1][0]));
    check({ctx, ":target_en"},  64'(target_en),  64'(m_target_en));
    check({ctx, ":pwm_en"},     64'(pwm_en),     64'(m_act[3][0]));
    check({ctx, ":target_x"},   64'(target_x),   64'(m_act[4]));
    check({ctx, ":target_v"},   64'(target_v),   64'(m_act[6]));
    check({ctx, ":target_a"},   64'(target_a),   64'(m_act[7]));
    check({ctx, ":max_v"},      64'(max_v),      64'(m_act[9]));
    check({ctx, ":max_a"},      64'(max_a),      64'(m_act[10]));
    check({ctx, ":max_a_near"}, 64'(max_a_near), 64'(m_act[15]));
  endtask

  task automatic cycle();
    @(posedge clk);
    #1;
  endtask

  // One bus access; optional coincident trigger; stb optionally held through ack.
  task automatic wb_access(input int adr, input bit we, input logic [63:0] dat,
                           input logic [7:0] sel, input bit trig, input bit hold);
    logic [63:0] exp_rd;
    int acks;
    exp_rd = exp_read(adr);
    wb.s_wb_adr_i = 8'(adr);
    wb.s_wb_we_i  = we;
    wb.s_wb_dat_i = dat;
    wb.s_wb_sel_i = sel;
    wb.s_wb_stb_i = 1'b1;
    update_trig   = trig;
    cycle();
    if (trig) model_trig();
    if (we) model_write(adr, dat, sel);
    model_settle();
    check("ack_latency", 64'(wb.s_wb_ack_o), 64'd1);
    if (!we) check($sformatf("rdata@%0h", adr), wb.s_wb_dat_o, exp_rd);
    acks = int'(wb.s_wb_ack_o);
    update_trig = 1'b0;
    if (!hold) wb.s_wb_stb_i = 1'b0;
    cycle();
    acks += int'(wb.s_wb_ack_o);
    wb.s_wb_stb_i = 1'b0;
    cycle();
    acks += int'(wb.s_wb_ack_o);
    check("ack_count", 64'(acks), 64'd1);
    check_outputs(we ? "wr" : "rd");
  endtask

  task automatic wb_write(input int adr, input logic [63:0] dat, input logic [7:0] sel);
    wb_access(adr, 1'b1, dat, sel, 1'b0, 1'b0);
  endtask

  task automatic wb_read(input int adr);
    wb_access(adr, 1'b0, 64'h0, 8'h00, 1'b0, 1'b0);
  endtask

  task automatic pulse_trig();
    update_trig = 1'b1;
    cycle();
    model_trig();
    model_settle();
    update_trig = 1'b0;
    check_outputs("trig");
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int adr;
    logic [63:0] dat;

    wb.s_wb_adr_i = '0;
    wb.s_wb_dat_i = '0;
    wb.s_wb_we_i  = 1'b0;
    wb.s_wb_sel_i = '0;
    wb.s_wb_stb_i = 1'b0;
    cur_x = $urandom;
    cur_v = $urandom;
    cur_a = $urandom;
    model_reset();

    repeat (3) cycle();
    reset = 1'b0;
    cycle();
    check("reset_ack", 64'(wb.s_wb_ack_o), 64'd0);
    check("reset_dat", wb.s_wb_dat_o, 64'd0);
    check_outputs("reset");

    wb_read(0);
    check("core_id_lit", wb.s_wb_dat_o, 64'h0000_0000_527a_f010);
    wb_read(4);

    wb_write(4, 64'd9000000, 8'h0f);
    wb_read(4);
    check("tx_before_trig", 64'(target_x), 64'd0);

    wb_write(2, 64'd1, 8'h01);
    pulse_trig();
    check("tx_after_trig", 64'(target_x), 64'd9000000);
    wb_read(2);
    check("req_cleared", wb.s_wb_dat_o, 64'd0);
    wb_write(4, 64'd5, 8'hff);
    pulse_trig();
    check("tx_no_request", 64'(target_x), 64'd9000000);

    wb_write(2, 64'd3, 8'h01);
    wb_write(10, 64'd10000, 8'hff);
    pulse_trig();
    check("max_a_auto1", 64'(max_a), 64'd10000);
    wb_write(10, 64'd20000, 8'hff);
    pulse_trig();
    check("max_a_auto2", 64'(max_a), 64'd20000);
    wb_read(2);
    check("auto_kept", wb.s_wb_dat_o, 64'd3);
    wb_write(2, 64'd0, 8'h01);

    wb_access(1, 1'b1, 64'd3, 8'h01, 1'b0, 1'b1);
    check("enable_immediate", 64'(enable), 64'd1);

    wb_write(4, 64'hffff_ffff_ffff_ff85, 8'hff);
    wb_write(2, 64'd1, 8'h01);
    wb_access(2, 1'b1, 64'd1, 8'h01, 1'b1, 1'b0);
    check("tx_coincident", 64'(target_x), 64'h0000_0000_ffff_ff85);
    wb_read(2);
    check("req_host_wins", wb.s_wb_dat_o, 64'd1);
    wb_read(4);
    check("sext_read", wb.s_wb_dat_o, 64'hffff_ffff_ffff_ff85);

    for (int it = 0; it < 300; it++) begin
      case ($urandom_range(0, 3))
        0: begin
          adr = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 31)) : xfer_regs[$urandom_range(0, 7)];
          if ($urandom_range(0, 3) == 0) adr = 2;
          dat = {$urandom, $urandom};
          wb_access(adr, 1'b1, dat, 8'($urandom), $urandom_range(0, 3) == 0, $urandom_range(0, 1) == 1);
        end
        1: wb_access(int'($urandom_range(0, 31)), 1'b0, 64'h0, 8'h00,
                     $urandom_range(0, 3) == 0, $urandom_range(0, 1) == 1);
        2: pulse_trig();
        default: begin
          cycle();
          model_settle();
          check_outputs("idle");
        end
      endcase
    end

    wb.s_wb_adr_i = 8'h06;
    wb.s_wb_we_i  = 1'b1;
    wb.s_wb_dat_i = 64'h1234;
    wb.s_wb_sel_i = 8'hff;
    wb.s_wb_stb_i = 1'b1;
    reset = 1'b1;
    cycle();
    check("reset_abort_ack", 64'(wb.s_wb_ack_o), 64'd0);
    wb.s_wb_stb_i = 1'b0;
    reset = 1'b0;
    model_reset();
    cycle();
    check("post_reset_ack", 64'(wb.s_wb_ack_o), 64'd0);
    check_outputs("post_reset");
    wb_read(6);
    wb_read(2);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
